// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream header width for the program loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_WORD,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    localparam int HDR_W = 16;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader that writes instruction memory and holds the core in reset until the image is in.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              WE,
    output logic [31:0]       W_Ins,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              CPU_RST,
    output logic              Done,
    output logic              Error
);

    localparam logic [HDR_W-1:0] CAP = HDR_W'(2 ** ADDR_W);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e FIN_S = S_CHK;
`else
    localparam state_e FIN_S = S_DONE;
`endif

    state_e             state_q, state_d;
    logic [HDR_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         idx_q, idx_d;
    logic [23:0]        shreg_q, shreg_d;
    logic [31:0]        w_ins_q, w_ins_d;
    logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif
    logic               take;
    logic [HDR_W-1:0]   hdr_n;
    logic [HDR_W-1:0]   addr_ext;

    assign take       = Byte_Valid & Byte_Ready;
    assign hdr_n      = {count_q[HDR_W-1:8], Byte_In};
    assign addr_ext   = HDR_W'(addr_q) + HDR_W'(1);
    assign Byte_Ready = (state_q == S_HDR_HI) | (state_q == S_HDR_LO) | (state_q == S_WORD) | (state_q == S_CHK);
    assign WE         = state_q == S_WRITE;
    assign CPU_RST    = state_q != S_DONE;
    assign Done       = state_q == S_DONE;
    assign Error      = state_q == S_ERR;
    assign W_Ins      = w_ins_q;
    assign W_Addr     = w_addr_q;

    // Next-state: header parse, byte assembly into words, write pulse and completion
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        w_ins_d  = w_ins_q;
        w_addr_d = w_addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: state_d = Start ? S_HDR_HI : state_q;
            S_HDR_HI: if (take) begin
                count_d = {Byte_In, count_q[7:0]};
                state_d = S_HDR_LO;
            end
            S_HDR_LO: if (take) begin
                count_d = hdr_n;
                addr_d  = '0;
                idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d  = '0;
`endif
                state_d = (hdr_n == '0) ? FIN_S : (hdr_n > CAP) ? S_ERR : S_WORD;
            end
            S_WORD: if (take) begin
                shreg_d = {shreg_q[15:0], Byte_In};
                idx_d   = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d  = csum_q ^ Byte_In;
`endif
                if (idx_q == 2'd3) begin
                    w_ins_d  = {shreg_q, Byte_In};
                    w_addr_d = addr_q;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                state_d = (addr_ext == count_q) ? FIN_S : S_WORD;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: if (take) state_d = (Byte_In == csum_q) ? S_DONE : S_ERR;
`endif
            default: ;
        endcase
    end

    // State registers; reset aborts any load in progress immediately
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            addr_q   <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            w_ins_q  <= '0;
            w_addr_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            w_ins_q  <= w_ins_d;
            w_addr_q <= w_addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

endmodule
